word_serializer: RTL and testbench
==================================

# word_serializer

Downstream neighbour of the packet receiver. Accepts 32-bit words from the receiver's `new_word_r`/`word_r`/`first_word_r`/`last_word_r` outputs into a small FIFO. Drives the receiver's `ready_out` for flow control. Shifts each word out MSB-first as a framed serial bit stream under a downstream bit-enable.

## Interface
- `WORD_W`, 32: word width; must be a power of two, 8 to 64.
- `DEPTH`, 2: FIFO depth in words; must be a power of two, 2 to 8.
- `clk`  in  1  Single clock; all logic on posedge.
- `rst`  in  1  Reset: synchronous, active-low.
- `new_word_r`  in  1  Word strobe from the receiver.
- `word_r`  in  WORD_W  Word payload.
- `first_word_r`  in  1  Word is the first of a packet; qualified by `new_word_r`.
- `last_word_r`  in  1  Word is the last of a packet; qualified by `new_word_r`.
- `ready_out`  out  1  Block can accept a word this cycle.
- `ser_en`  in  1  Downstream consumes the presented bit this cycle.
- `ser_valid`  out  1  `ser_data` holds a valid bit.
- `ser_data`  out  1  Serial bit.
- `ser_sop`  out  1  Presented bit is the first bit of a first-tagged word.
- `ser_eop`  out  1  Presented bit is the final bit of a last-tagged word.
- `ovf`  out  1  Sticky overflow flag.

## Operation
- **FIFO.** Holds `DEPTH` entries of {word, first, last}, with a `$clog2(DEPTH)+1`-bit count.
  - Push: `new_word_r && ready_out`.
  - `ready_out = (count != DEPTH)`, decoded from the registered count only.
  - `new_word_r` while `ready_out` is 0: word dropped, FIFO unchanged, `ovf` set. `ovf` is cleared only by reset.
- **Shifter.** Consists of a WORD_W-bit shift register, a bit counter of `$clog2(WORD_W)` bits, and sop/eop tag registers.
- **FSM states:**
  - IDLE: shifter empty, `ser_valid` = 0.
    - FIFO non-empty → pop head into shifter, bit counter = 0, go to SHIFT.
  - SHIFT: `ser_valid` = 1, `ser_data` = shift register MSB.
    - On `ser_en`: shift left by 1, counter +1.
    - On `ser_en` with counter = WORD_W-1:
      - With SER_PARITY_EN: go to PARITY.
      - Otherwise, if FIFO non-empty: pop and reload, stay in SHIFT (no bubble).
      - Otherwise: go to IDLE.
  - PARITY (only with SER_PARITY_EN): `ser_valid` = 1, `ser_data` = even parity of the word.
    - On `ser_en`: same reload/IDLE decision as the final bit of SHIFT.
- **Frame markers.**
  - `ser_sop` = 1 only while bit index 0 of a first-tagged word is presented.
  - `ser_eop` = 1 only while the final bit of a last-tagged word is presented: bit WORD_W-1, or the parity bit when SER_PARITY_EN is defined.
  - A word tagged both first and last asserts both markers at their respective bits.
- **Flow control.** `ser_en` while `ser_valid` = 0 is ignored. While `ser_en` is low, all `ser_*` outputs hold.
- **Simultaneous push and pop.** Allowed. The count is unchanged.
  - When the FIFO is full, `ready_out` is 0 that cycle even if a pop occurs. No combinational path from `ser_en` to `ready_out`.

## Timing
- **Reset values** (rst = 0 at a posedge): FIFO count 0, FSM in IDLE. Outputs: `ready_out` = 1, `ser_valid` = 0, `ser_data` = 0, `ser_sop` = 0, `ser_eop` = 0, `ovf` = 0.
- **Reset mid-word** flushes the FIFO and the shifter. No partial word resumes after reset.
- **Latency.** Word sampled at edge E0 into an empty FIFO with FSM in IDLE → popped at E1 → `ser_valid`, first bit and `ser_sop` visible after E1.
- **Throughput.**
  - One bit per cycle with `ser_en` held high.
  - WORD_W cycles per word, or WORD_W+1 with parity.
  - Back-to-back words have zero idle cycles.
- **Outputs.** All outputs are registered or decoded from registers only.

## Configuration
- Macro: `SER_PARITY_EN`.
- **Defined:** each word is followed by one even-parity bit (XOR of all WORD_W bits). The PARITY state exists, and `ser_eop` moves to the parity bit.
- **Undefined:** no PARITY state and no parity bit. Each word occupies exactly WORD_W serial bits.

## Test plan
- **Single word.** Reset, then push `F00CC05A` with first = 1 and last = 0, `ser_en` = 1.
  - `ser_valid` rises 2 edges after the push.
  - Bits `1111_0000_0000_1100_1100_0000_0101_1010`.
  - `ser_sop` on bit 0 only.
  - With parity: bit 32 = 0.
- **Four-word packet, no gaps.** Push `F00CC05A`, `7D000007`, `00000020`, `FE000000`, with last = 1 on the fourth.
  - 128 contiguous valid bits (132 with parity; `7D000007` parity = 1).
  - `ser_eop` only on the final bit.
- **Backpressure.** Hold `ser_en` = 0 after the first push, then push 2 more words.
  - `ready_out` drops to 0 once the FIFO is full.
  - A third push while `ready_out` = 0 is dropped and `ovf` = 1.
  - Serial output holds bit 0 steady.
- **Stall mid-word.** Toggle `ser_en` 1/0 every cycle.
  - Bit order is preserved.
  - Each bit is held exactly until consumed.
- **Mid-word reset.** Assert rst = 0 at bit 10.
  - Next cycle: `ser_valid` = 0, `ready_out` = 1, `ovf` = 0.
  - A fresh push of `00000020` serializes from bit 0 with the correct `ser_sop`.
- **Simultaneous events.** FIFO full, the shifter pops on its final bit, and `new_word_r` is asserted in the same cycle.
  - That word is dropped (`ready_out` was 0).
  - Count becomes DEPTH-1.
  - `ready_out` = 1 next cycle.

Source files
------------

// File: rtl/word_serializer_if.sv
// word_serializer_if: receiver word bus plus downstream serial port of word_serializer.
interface word_serializer_if #(
  parameter int WORD_W = 32
);
  logic new_word_r;
  logic [WORD_W-1:0] word_r;
  logic first_word_r;
  logic last_word_r;
  logic ready_out;
  logic ser_en;
  logic ser_valid;
  logic ser_data;
  logic ser_sop;
  logic ser_eop;
  modport master (
    output new_word_r, word_r, first_word_r, last_word_r, ser_en,
    input ready_out, ser_valid, ser_data, ser_sop, ser_eop
  );
  modport slave (
    input new_word_r, word_r, first_word_r, last_word_r, ser_en,
    output ready_out, ser_valid, ser_data, ser_sop, ser_eop
  );
endinterface

// File: rtl/word_serializer.sv
// word_serializer: FIFO-buffered MSB-first word serializer; define SER_PARITY_EN to append an even-parity bit per word.
module word_serializer #(
  parameter int WORD_W = 32,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  word_serializer_if.slave bus,
  output logic ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WORD_W);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef SER_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
  logic par;
`endif
  logic [WORD_W-1:0] mem_w [DEPTH];
  logic [DEPTH-1:0] mem_f;
  logic [DEPTH-1:0] mem_l;
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [CW-1:0] count;
  logic [1:0] state;
  logic [WORD_W-1:0] sh;
  logic [BW-1:0] cnt;
  logic sop_r;
  logic eop_r;
  logic push;
  logic pop;
  logic fin;
  logic last_bit;
  assign bus.ready_out = count != CW'(DEPTH);
  assign push = bus.new_word_r && bus.ready_out;
  assign last_bit = cnt == BW'(WORD_W - 1);
  assign bus.ser_valid = state != IDLE;
  assign bus.ser_sop = state == SHIFT && cnt == '0 && sop_r;
`ifdef SER_PARITY_EN
  assign fin = state == PARITY && bus.ser_en;
  assign bus.ser_data = state == PARITY ? par : sh[WORD_W-1];
  assign bus.ser_eop = state == PARITY && eop_r;
`else
  assign fin = state == SHIFT && bus.ser_en && last_bit;
  assign bus.ser_data = sh[WORD_W-1];
  assign bus.ser_eop = state == SHIFT && last_bit && eop_r;
`endif
  assign pop = (state == IDLE || fin) && count != '0;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_w[wr] <= bus.word_r;
      mem_f[wr] <= bus.first_word_r;
      mem_l[wr] <= bus.last_word_r;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      ovf <= 1'b0;
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      sop_r <= 1'b0;
      eop_r <= 1'b0;
`ifdef SER_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (bus.new_word_r && !bus.ready_out) ovf <= 1'b1;
      if (pop) begin
        state <= SHIFT;
        sh <= mem_w[rd];
        cnt <= '0;
        sop_r <= mem_f[rd];
        eop_r <= mem_l[rd];
`ifdef SER_PARITY_EN
        par <= ^mem_w[rd];
`endif
      end else if (fin) begin
        state <= IDLE;
      end else if (state == SHIFT && bus.ser_en) begin
        sh <= sh << 1;
        cnt <= cnt + 1'b1;
`ifdef SER_PARITY_EN
        if (last_bit) state <= PARITY;
`endif
      end
    end
  end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: vector table, corner sequences and random traffic against a queue-based model.
module tb_word_serializer;
  localparam int W = 32;
  localparam int D = 2;
`ifdef SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  typedef struct packed {logic [W-1:0] w; logic f; logic l;} ent_t;
  typedef struct {logic [W-1:0] w; logic f; logic l; logic par;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ovf;
  int tests = 0;
  int fails = 0;
  int cycn = 0;
  ent_t fq[$];
  logic [2:0] fr[$];
  logic movf = 1'b0;
  logic [2:0] got[$];
  int gcyc[$];
  vec_t pkt[4];
  always #5 clk = ~clk;
  word_serializer_if #(.WORD_W(W)) bus();
  word_serializer #(.WORD_W(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus), .ovf(ovf));
  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // Expected serial frame of a word: {data, sop, eop} per presented bit.
  function automatic void load(input ent_t e);
    fr.delete();
    for (int i = 0; i < W; i++) fr.push_back({e.w[W-1-i], e.f && i == 0, e.l && i == NB - 1});
`ifdef SER_PARITY_EN
    fr.push_back({^e.w, 1'b0, e.l});
`endif
  endfunction
  task automatic cyc(input logic nw, input logic [W-1:0] w, input logic f, input logic l, input logic en);
    logic [2:0] cur;
    logic [5:0] a;
    logic [5:0] e;
    logic cons;
    logic ld;
    logic acc;
    cur = fr.size() != 0 ? fr[0] : 3'b000;
    a = {bus.ready_out, bus.ser_valid, bus.ser_valid & bus.ser_data, bus.ser_sop, bus.ser_eop, ovf};
    e = {1'(fq.size() < D), 1'(fr.size() != 0), cur, movf};
    chk($sformatf("model@%0d", cycn), W'(a), W'(e));
    if (bus.ser_valid && en) begin
      got.push_back({bus.ser_data, bus.ser_sop, bus.ser_eop});
      gcyc.push_back(cycn);
    end
    bus.new_word_r = nw;
    bus.word_r = w;
    bus.first_word_r = f;
    bus.last_word_r = l;
    bus.ser_en = en;
    @(posedge clk);
    cons = fr.size() != 0 && en;
    ld = (fr.size() == 0 || (cons && fr.size() == 1)) && fq.size() != 0;
    acc = nw && fq.size() < D;
    if (nw && !acc) movf = 1'b1;
    if (cons) void'(fr.pop_front());
    if (ld) load(fq.pop_front());
    if (acc) fq.push_back('{w, f, l});
    #1;
    cycn++;
  endtask
  task automatic reset_dut();
    rst = 1'b0;
    bus.new_word_r = 1'b0;
    bus.word_r = '0;
    bus.first_word_r = 1'b0;
    bus.last_word_r = 1'b0;
    bus.ser_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    fq.delete();
    fr.delete();
    movf = 1'b0;
    got.delete();
    gcyc.delete();
  endtask
  task automatic push(input logic [W-1:0] w, input logic f, input logic l, input logic en);
    int k = 0;
    while (!bus.ready_out && k < 200) begin
      cyc(1'b0, '0, 1'b0, 1'b0, en);
      k++;
    end
    chk("push_ready", W'(bus.ready_out), 1);
    cyc(1'b1, w, f, l, en);
  endtask
  task automatic drain(input int n, input logic tog);
    int k = 0;
    while (got.size() < n && k < 4000) begin
      cyc(1'b0, '0, 1'b0, 1'b0, tog ? ~k[0] : 1'b1);
      k++;
    end
    if (got.size() < n) chk("drain_timeout", W'(got.size()), W'(n));
  endtask
  function automatic logic [W-1:0] got_word(input int k);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) r = {r[W-2:0], got[k*NB+i][2]};
    return r;
  endfunction
  function automatic int nflag(input int j);
    int s = 0;
    foreach (got[i]) s += int'(got[i][j]);
    return s;
  endfunction
  initial begin
    logic [W-1:0] a;
    int k;
    pkt = '{'{32'hF00CC05A, 1'b1, 1'b0, 1'b0}, '{32'h7D000007, 1'b0, 1'b0, 1'b1},
            '{32'h00000020, 1'b0, 1'b0, 1'b1}, '{32'hFE000000, 1'b0, 1'b1, 1'b1}};
    reset_dut();
    chk("reset_out", W'({bus.ready_out, bus.ser_valid, bus.ser_data, bus.ser_sop, bus.ser_eop, ovf}), W'(6'b100000));
    cyc(1'b1, 32'hF00CC05A, 1'b1, 1'b0, 1'b1);
    chk("lat_e0_valid", W'(bus.ser_valid), 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("lat_e1_valid", W'(bus.ser_valid), 1);
    chk("lat_sop", W'(bus.ser_sop), 1);
    drain(NB, 1'b0);
    a = 32'b1111_0000_0000_1100_1100_0000_0101_1010;
    chk("single_bits", got_word(0), a);
    chk("single_sop_cnt", W'(nflag(1)), 1);
    chk("single_sop_pos", W'(got[0][1]), 1);
    chk("single_eop_cnt", W'(nflag(0)), 0);
`ifdef SER_PARITY_EN
    chk("single_par", W'(got[W][2]), 0);
`endif
    reset_dut();
    for (int i = 0; i < 4; i++) push(pkt[i].w, pkt[i].f, pkt[i].l, 1'b1);
    drain(4 * NB, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pkt_word%0d", i), got_word(i), pkt[i].w);
`ifdef SER_PARITY_EN
      chk($sformatf("pkt_par%0d", i), W'(got[i*NB+W][2]), W'(pkt[i].par));
`endif
    end
    chk("pkt_sop_cnt", W'(nflag(1)), 1);
    chk("pkt_sop_pos", W'(got[0][1]), 1);
    chk("pkt_eop_cnt", W'(nflag(0)), 1);
    chk("pkt_eop_pos", W'(got[4*NB-1][0]), 1);
    chk("pkt_contig", W'(gcyc[4*NB-1] - gcyc[0]), W'(4 * NB - 1));
    reset_dut();
    push(pkt[0].w, 1'b1, 1'b0, 1'b0);
    push(pkt[1].w, 1'b0, 1'b0, 1'b0);
    push(pkt[2].w, 1'b0, 1'b1, 1'b0);
    chk("bp_ready", W'(bus.ready_out), 0);
    chk("bp_hold", W'({bus.ser_valid, bus.ser_data, bus.ser_sop}), W'(3'b111));
    cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    chk("bp_ovf", W'(ovf), 1);
    repeat (5) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("bp_hold2", W'({bus.ser_valid, bus.ser_data, bus.ser_sop}), W'(3'b111));
    drain(3 * NB, 1'b0);
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("bp_count", W'(got.size()), W'(3 * NB));
    for (int i = 0; i < 3; i++) chk($sformatf("bp_word%0d", i), got_word(i), pkt[i].w);
    reset_dut();
    push(pkt[0].w, 1'b1, 1'b0, 1'b0);
    push(pkt[1].w, 1'b0, 1'b1, 1'b0);
    drain(2 * NB, 1'b1);
    chk("stall_word0", got_word(0), pkt[0].w);
    chk("stall_word1", got_word(1), pkt[1].w);
    chk("stall_rate", W'(gcyc[2*NB-1] - gcyc[0]), W'(2 * (2 * NB - 1)));
    reset_dut();
    push(pkt[0].w, 1'b1, 1'b0, 1'b0);
    push(pkt[1].w, 1'b0, 1'b0, 1'b0);
    push(pkt[2].w, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    drain(10, 1'b0);
    chk("mid_pre_ovf", W'(ovf), 1);
    reset_dut();
    chk("mid_reset", W'({bus.ready_out, bus.ser_valid, ovf}), W'(3'b100));
    push(32'h00000020, 1'b1, 1'b1, 1'b1);
    drain(NB, 1'b0);
    chk("mid_word", got_word(0), 32'h00000020);
    chk("mid_sop", W'({got[0][1], nflag(1)}), W'(33'h1_0000_0001));
    chk("mid_eop", W'(got[NB-1][0]), 1);
    reset_dut();
    push(pkt[0].w, 1'b1, 1'b0, 1'b0);
    push(pkt[1].w, 1'b0, 1'b0, 1'b0);
    push(pkt[2].w, 1'b0, 1'b1, 1'b0);
    drain(NB - 1, 1'b0);
    chk("sim_full", W'(bus.ready_out), 0);
    cyc(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);
    chk("sim_ready", W'(bus.ready_out), 1);
    chk("sim_ovf", W'(ovf), 1);
    drain(3 * NB, 1'b0);
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("sim_count", W'(got.size()), W'(3 * NB));
    for (int i = 0; i < 3; i++) chk($sformatf("sim_word%0d", i), got_word(i), pkt[i].w);
    reset_dut();
    repeat (3000) cyc(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    k = 0;
    while ((fr.size() != 0 || fq.size() != 0) && k < 1000) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      k++;
    end
    chk("rand_drain", W'(fr.size() + fq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
